// File: rtl/x_in_to_single_out_if.sv
// Handshake bundle for the parallel-to-serial collector: parallel word and
// start request in, serial bit stream with valid/ready and frame markers out.
interface x_in_to_single_out_if #(
   parameter int unsigned NUM_INS = 8
);
   logic [NUM_INS-1:0] in;
   logic               start;
   logic               out_ready;
   logic               out;
   logic               out_valid;
   logic               out_first;
   logic               out_last;
   logic               busy;

   // master: the agent supplying words and consuming the serial stream
   modport master (
      output in, start, out_ready,
      input  out, out_valid, out_first, out_last, busy
   );

   // slave: the collector itself
   modport slave (
      input  in, start, out_ready,
      output out, out_valid, out_first, out_last, busy
   );
endinterface

// File: rtl/x_in_to_single_out.sv
// Parallel-to-serial collector: snapshots an NUM_INS-bit word on start and
// streams it LSB first, one bit per accepted beat, with first/last markers.
module x_in_to_single_out #(
   parameter int unsigned NUM_INS = 8
) (
   input logic                 clk,
   input logic                 rst,
   x_in_to_single_out_if.slave bus
);

   localparam int unsigned    CW   = (NUM_INS > 1) ? $clog2(NUM_INS) : 1;
   localparam logic [CW-1:0]  LAST = CW'(NUM_INS - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [NUM_INS-1:0] snap, snap_n;

   logic out_q, out_n;
   logic valid_q, valid_n;
   logic first_q, first_n;
   logic last_q, last_n;
   logic accept;
   logic bit_n;

   assign accept = valid_q & bus.out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         snap    <= '0;
         out_q   <= 1'b0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         snap    <= snap_n;
         out_q   <= out_n;
         valid_q <= valid_n;
         first_q <= first_n;
         last_q  <= last_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      snap_n  = snap;

      unique case (state)
         IDLE: begin
            if (bus.start) begin
               snap_n  = bus.in;
               cnt_n   = '0;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (accept) begin
               if (cnt == LAST) begin
                  cnt_n = '0;
                  // start is honoured only on the accepted last beat (back-to-back)
                  if (bus.start) begin
                     snap_n = bus.in;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from the next-state values, so a stalled beat
   // recomputes identical values and holds without a separate enable.
   always_comb begin
      bit_n = 1'b0;
      for (int unsigned i = 0; i < NUM_INS; i++) begin
         if (cnt_n == CW'(i)) begin
            bit_n = snap_n[i];
         end
      end
      valid_n = (state_n == SHIFT);
      out_n   = valid_n & bit_n;
      first_n = valid_n & (cnt_n == '0);
      last_n  = valid_n & (cnt_n == LAST);
   end

   assign bus.out       = out_q;
   assign bus.out_valid = valid_q;
   assign bus.out_first = first_q;
   assign bus.out_last  = last_q;
   assign bus.busy      = valid_q;

endmodule

// File: tb/tb_x_in_to_single_out.sv
// Directed bench for x_in_to_single_out at NUM_INS = 8, 1 and 5.
module tb_x_in_to_single_out;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   x_in_to_single_out_if #(.NUM_INS(8)) a_if ();
   x_in_to_single_out_if #(.NUM_INS(1)) b_if ();
   x_in_to_single_out_if #(.NUM_INS(5)) c_if ();

   x_in_to_single_out #(.NUM_INS(8)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
   x_in_to_single_out #(.NUM_INS(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
   x_in_to_single_out #(.NUM_INS(5)) dut_c (.clk(clk), .rst(rst), .bus(c_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // packed view: {busy, out_valid, out, out_first, out_last}
   function automatic logic [4:0] obs_a();
      return {a_if.busy, a_if.out_valid, a_if.out, a_if.out_first, a_if.out_last};
   endfunction
   function automatic logic [4:0] obs_b();
      return {b_if.busy, b_if.out_valid, b_if.out, b_if.out_first, b_if.out_last};
   endfunction
   function automatic logic [4:0] obs_c();
      return {c_if.busy, c_if.out_valid, c_if.out, c_if.out_first, c_if.out_last};
   endfunction

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic launch_a(input logic [7:0] w);
      a_if.in    = w;
      a_if.start = 1'b1;
      @(negedge clk);
   endtask

   // Called at the negedge where beat 0 of word w is visible.
   task automatic play_a(input string tag, input logic [7:0] w, input logic [7:0] stall_mask,
                         input int ign_beat, input logic [7:0] ign_word,
                         input bit b2b, input logic [7:0] b2b_word);
      logic [4:0] e;
      for (int i = 0; i < 8; i++) begin
         a_if.start = 1'b0;
         e = {1'b1, 1'b1, w[i], (i == 0), (i == 7)};
         chk($sformatf("%s beat%0d", tag, i), obs_a(), e);
         if (i == ign_beat) begin
            a_if.in    = ign_word;
            a_if.start = 1'b1;
         end
         if (i == 7 && b2b) begin
            a_if.in    = b2b_word;
            a_if.start = 1'b1;
         end
         if (stall_mask[i]) begin
            a_if.out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk($sformatf("%s stall%0d", tag, i), obs_a(), e);
            end
            a_if.out_ready = 1'b1;
         end
         @(negedge clk);
      end
      a_if.start = 1'b0;
      if (!b2b) chk($sformatf("%s idle", tag), obs_a(), 5'b00000);
   endtask

   initial begin
      logic [4:0] word5;
      n_chk  = 0;
      n_fail = 0;
      rst = 1'b0;
      a_if.in = '0; a_if.start = 1'b0; a_if.out_ready = 1'b1;
      b_if.in = '0; b_if.start = 1'b0; b_if.out_ready = 1'b1;
      c_if.in = '0; c_if.start = 1'b0; c_if.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("reset a", obs_a(), 5'b00000);
      chk("reset b", obs_b(), 5'b00000);
      chk("reset c", obs_c(), 5'b00000);
      rst = 1'b1;
      @(negedge clk);
      chk("post-reset idle", obs_a(), 5'b00000);

      // reset mid-frame aborts asynchronously and nothing resumes
      launch_a(8'hFF);
      a_if.start = 1'b0;
      @(negedge clk);
      chk("pre-abort beat1", obs_a(), 5'b11100);
      #2 rst = 1'b0;
      #1 chk("async abort", obs_a(), 5'b00000);
      @(negedge clk);
      chk("held in reset", obs_a(), 5'b00000);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("no resume", obs_a(), 5'b00000);
      end

      // single frame A5 -> 1,0,1,0,0,1,0,1
      launch_a(8'hA5);
      play_a("a5", 8'hA5, 8'h00, -1, 8'h00, 1'b0, 8'h00);

      // backpressure on beats 2 and 5: 3C -> 0,0,1,1,1,1,0,0
      launch_a(8'h3C);
      play_a("bp3c", 8'h3C, 8'b0001_0010, -1, 8'h00, 1'b0, 8'h00);

      // back-to-back FF then 01 with no idle gap
      launch_a(8'hFF);
      play_a("b2b ff", 8'hFF, 8'h00, -1, 8'h00, 1'b1, 8'h01);
      play_a("b2b 01", 8'h01, 8'h00, -1, 8'h00, 1'b0, 8'h00);

      // start at beat 3 with a different word is dropped
      launch_a(8'h96);
      play_a("ign", 8'h96, 8'h00, 2, 8'h5A, 1'b0, 8'h00);
      @(negedge clk);
      chk("ign not queued", obs_a(), 5'b00000);

      // NUM_INS = 1: each beat is first and last; back-to-back then idle
      b_if.in    = 1'b1;
      b_if.start = 1'b1;
      @(negedge clk);
      chk("n1 beat", obs_b(), 5'b11111);
      b_if.in = 1'b0;
      @(negedge clk);
      chk("n1 b2b", obs_b(), 5'b11011);
      b_if.start = 1'b0;
      @(negedge clk);
      chk("n1 idle", obs_b(), 5'b00000);

      // NUM_INS = 5: 10110 -> 0,1,1,0,1 then 01001 -> 1,0,0,1,0
      for (int f = 0; f < 2; f++) begin
         word5 = (f == 0) ? 5'b10110 : 5'b01001;
         c_if.in    = word5;
         c_if.start = 1'b1;
         @(negedge clk);
         c_if.start = 1'b0;
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("n5 f%0d beat%0d", f, i), obs_c(),
                {1'b1, 1'b1, word5[i], (i == 0), (i == 4)});
            @(negedge clk);
         end
         chk($sformatf("n5 f%0d idle", f), obs_c(), 5'b00000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/x_in_to_single_out.md
Name: x_in_to_single_out

Overview:
- Parallel-to-serial collector: the mirror of the existing one-input/N-output distributor.
- On a start pulse, snapshots an NUM_INS-bit input word and streams it one bit per accepted beat on a single output, LSB first, with valid/ready backpressure and first/last frame markers.
- Used for utilization and bring-up testing: wide internal buses fold onto one pin, and the distributor on the far side re-expands them.

Parameters:
- NUM_INS, 8, number of parallel input bits per frame (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in  input  NUM_INS  parallel word, sampled only on an accepted start
- start  input  1  request to capture `in` and begin a frame
- out_ready  input  1  downstream accepts current beat when high with out_valid
- out  output  1  current serial bit
- out_valid  output  1  out/out_first/out_last are valid
- out_first  output  1  current beat is bit 0 of a frame
- out_last  output  1  current beat is bit NUM_INS-1 of a frame
- busy  output  1  frame in progress (equals out_valid)

Behaviour:
- Counter width CW = max(1, $clog2(NUM_INS)). Snapshot register snap[NUM_INS-1:0]. States IDLE, SHIFT.
- Reset (rst low, asynchronous):
  - state=IDLE, cnt=0, snap=0.
  - out=0, out_valid=0, out_first=0, out_last=0, busy=0.
  - Reset mid-frame aborts the frame; no partial frame resumes after release.
- All outputs are registered; there is no combinational path from any input to any output.
- Accept = out_valid & out_ready.
- IDLE:
  - start=1 at edge N: snap<=in, cnt<=0, state<=SHIFT.
  - At N+1: out_valid=1, out=in[0] as sampled at N, out_first=1, out_last=(NUM_INS==1).
  - start=0: remain IDLE, outputs hold reset values.
- SHIFT:
  - out=snap[cnt], out_first=(cnt==0), out_last=(cnt==NUM_INS-1).
  - No accept: all outputs and cnt hold stable; `in` and `start` are ignored.
  - Accept and cnt<NUM_INS-1: cnt<=cnt+1, next bit presented on the following cycle.
  - Accept and cnt==NUM_INS-1, start=1: back-to-back. snap<=in, cnt<=0, stay SHIFT; next cycle presents the new frame's bit 0 with out_first=1 and no idle gap.
  - Accept and cnt==NUM_INS-1, start=0: state<=IDLE, out_valid<=0, out_first<=0, out_last<=0, out<=0.
- start asserted in SHIFT on any cycle other than the accepted last beat is dropped, not queued.
- Throughput: one bit per cycle with out_ready held high. A frame occupies exactly NUM_INS valid cycles.
- NUM_INS=1: every beat has out_first=out_last=1; cnt stays 0.
- cnt never exceeds NUM_INS-1, including for non-power-of-2 NUM_INS (e.g. 5 wraps 4 to 0).

Test Plan:
- Reset: hold rst=0 mid-frame, pulse clk -> all outputs 0, state IDLE; after release, out_valid stays 0 until start.
- Single frame, NUM_INS=8, in=8'hA5, start 1 cycle, out_ready=1 -> out sequence 1,0,1,0,0,1,0,1 on cycles N+1..N+8; out_first only at N+1, out_last only at N+8; out_valid=0 at N+9.
- Backpressure: in=8'h3C, out_ready low on beats 2 and 5 for 3 cycles each -> out/flags held constant while stalled; full sequence 0,0,1,1,1,1,0,0 is delivered with no loss or duplication.
- Back-to-back: start high on the accepted last beat of frame 8'hFF, in=8'h01 -> next cycle out=1 with out_first=1, followed by seven 0s; no idle cycle between frames.
- Ignored start: start pulsed at beat 3 of a frame with a different `in` -> current frame completes unchanged, then IDLE.
- Parameter sweep NUM_INS=1 and 5: in=1'b1 gives one beat with first=last=1; in=5'b10110 gives 0,1,1,0,1, then cnt returns to 0.
